// File: rtl/airlight_frame_ctrl.sv
// airlight_frame_ctrl
// Frame-level sequencer for the atmospheric-light estimator. It clears the
// estimator at start of frame and feeds it interior windows only. It checks
// the frame geometry, waits out the estimator pipeline, and then holds the
// per-frame (R,G,B) result in a valid/ready output register.
module airlight_frame_ctrl #(
  parameter int IMG_W   = 640,
  parameter int IMG_H   = 480,
  parameter int EST_LAT = 2,
  parameter int DW      = 8
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          win_valid,
  input  logic          win_sof,
  input  logic          win_eof,
  output logic          est_clr,
  output logic          est_en,
  input  logic [DW-1:0] est_r,
  input  logic [DW-1:0] est_g,
  input  logic [DW-1:0] est_b,
  output logic [DW-1:0] a_r,
  output logic [DW-1:0] a_g,
  output logic [DW-1:0] a_b,
  output logic          a_valid,
  input  logic          a_ready,
  output logic          busy,
  output logic          overrun,
  output logic          size_err,
  input  logic          err_clr
);

  localparam int CW  = $clog2(IMG_W);
  localparam int RW  = $clog2(IMG_H);
  localparam int DCW = $clog2(EST_LAT + 1);

  localparam logic [CW-1:0]  COL_ONE        = CW'(1);
  localparam logic [CW-1:0]  COL_INNER_LAST = CW'(IMG_W - 2);
  localparam logic [CW-1:0]  COL_LAST       = CW'(IMG_W - 1);
  localparam logic [RW-1:0]  ROW_ONE        = RW'(1);
  localparam logic [RW-1:0]  ROW_INNER_LAST = RW'(IMG_H - 2);
  localparam logic [RW-1:0]  ROW_LAST       = RW'(IMG_H - 1);
  localparam logic [DCW-1:0] DRAIN_INIT     = DCW'(EST_LAT);
  localparam logic [DCW-1:0] DRAIN_ONE      = DCW'(1);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_RUN   = 2'd1;
  localparam logic [1:0] S_DRAIN = 2'd2;

  logic [1:0]    r_state;
  logic [CW-1:0] r_col;
  logic [RW-1:0] r_row;
  logic          r_ovf;
  logic [DCW-1:0] r_drain;
  logic [DW-1:0] r_a_r;
  logic [DW-1:0] r_a_g;
  logic [DW-1:0] r_a_b;
  logic          r_a_valid;
  logic          r_overrun;
  logic          r_size_err;

  logic w_sof;
  logic w_interior;
  logic w_geom_ok;
  logic w_capture;
  logic w_size_err_set;
  logic w_overrun_set;

  // Decode the current window against the registered state and coordinates.
  always_comb begin
    w_sof      = win_valid & win_sof;
    w_interior = (r_row >= ROW_ONE) && (r_row <= ROW_INNER_LAST) &&
                 (r_col >= COL_ONE) && (r_col <= COL_INNER_LAST);
    w_geom_ok  = (r_col == COL_LAST) && (r_row == ROW_LAST) && !r_ovf;
    w_capture  = (r_state == S_DRAIN) && (r_drain == '0);
    est_clr    = w_sof & (r_state != S_DRAIN);
    est_en     = (r_state == S_RUN) & win_valid & ~win_sof & w_interior;
    w_size_err_set = ((r_state == S_DRAIN) & win_valid) |
                     ((r_state == S_IDLE) & w_sof & win_eof) |
                     ((r_state == S_RUN) & win_valid &
                      (win_sof | (win_eof & ~w_geom_ok)));
    w_overrun_set  = w_capture & r_a_valid & ~a_ready;
  end

  // Frame sequencer: raster tracking in RUN, pipeline wait in DRAIN.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= S_IDLE;
      r_col   <= '0;
      r_row   <= '0;
      r_ovf   <= 1'b0;
      r_drain <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_sof && !win_eof) begin
            r_state <= S_RUN;
            r_col   <= COL_ONE;
            r_row   <= '0;
            r_ovf   <= 1'b0;
          end
        end
        S_RUN: begin
          if (win_valid) begin
            if (win_sof && win_eof) begin
              r_state <= S_IDLE;
            end else if (win_sof) begin
              r_col <= COL_ONE;
              r_row <= '0;
              r_ovf <= 1'b0;
            end else if (win_eof) begin
              if (w_geom_ok) begin
                r_state <= S_DRAIN;
                r_drain <= DRAIN_INIT;
              end else begin
                r_state <= S_IDLE;
              end
            end else if (r_col == COL_LAST) begin
              r_col <= '0;
              if (r_row == ROW_LAST) begin
                r_ovf <= 1'b1;
              end else begin
                r_row <= r_row + ROW_ONE;
              end
            end else begin
              r_col <= r_col + COL_ONE;
            end
          end
        end
        S_DRAIN: begin
          if (r_drain == '0) begin
            r_state <= S_IDLE;
          end else begin
            r_drain <= r_drain - DRAIN_ONE;
          end
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  // Result register: capture at end of drain, clear on downstream accept.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_a_r     <= '0;
      r_a_g     <= '0;
      r_a_b     <= '0;
      r_a_valid <= 1'b0;
    end else if (w_capture) begin
      r_a_r     <= est_r;
      r_a_g     <= est_g;
      r_a_b     <= est_b;
      r_a_valid <= 1'b1;
    end else if (r_a_valid && a_ready) begin
      r_a_valid <= 1'b0;
    end
  end

  // Sticky error flags; a new set event beats a coincident clear.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_overrun  <= 1'b0;
      r_size_err <= 1'b0;
    end else begin
      r_overrun  <= w_overrun_set  | (r_overrun  & ~err_clr);
      r_size_err <= w_size_err_set | (r_size_err & ~err_clr);
    end
  end

  assign a_r      = r_a_r;
  assign a_g      = r_a_g;
  assign a_b      = r_a_b;
  assign a_valid  = r_a_valid;
  assign busy     = (r_state != S_IDLE);
  assign overrun  = r_overrun;
  assign size_err = r_size_err;

endmodule

// File: tb/tb_airlight_frame_ctrl.sv
// Testbench for airlight_frame_ctrl on a 4x3 frame with a two-cycle estimator.
// A frame-level model predicts every output each cycle, and directed
// literal checks pin the model to hand-computed results.
module tb_airlight_frame_ctrl;

   localparam int W   = 4;
   localparam int H   = 3;
   localparam int LAT = 2;
   localparam int DW  = 8;

   logic          clk = 1'b0;
   logic          reset;
   logic          winValid, winSof, winEof;
   logic          estClr, estEn;
   logic [DW-1:0] estR, estG, estB;
   logic [DW-1:0] aR, aG, aB;
   logic          aValid, aReady, busy, overrun, sizeErr, errClr;

   int nCompared  = 0;
   int nMismatch  = 0;
   int clrCount   = 0;
   int enCount    = 0;
   int validCount = 0;
   logic prevValid = 1'b0;

   // Model state: 0 waiting for sof, 1 inside a frame, 2 waiting on estimator
   int            mMode;
   int            mIdx;
   int            mDrain;
   logic          eValid, eOverrun, eSizeErr;
   logic [DW-1:0] eR, eG, eB;

   airlight_frame_ctrl #(.IMG_W(W), .IMG_H(H), .EST_LAT(LAT), .DW(DW)) dut (
      .clk(clk), .reset(reset),
      .win_valid(winValid), .win_sof(winSof), .win_eof(winEof),
      .est_clr(estClr), .est_en(estEn),
      .est_r(estR), .est_g(estG), .est_b(estB),
      .a_r(aR), .a_g(aG), .a_b(aB),
      .a_valid(aValid), .a_ready(aReady),
      .busy(busy), .overrun(overrun), .size_err(sizeErr),
      .err_clr(errClr)
   );

   // Free-running clock
   always #5 clk = ~clk;

   // Compare one observed value against its expectation
   task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
      nCompared++;
      if (act !== exp) begin
         nMismatch++;
         $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic modelReset();
      mMode    = 0;
      mIdx     = 0;
      mDrain   = 0;
      eValid   = 1'b0;
      eOverrun = 1'b0;
      eSizeErr = 1'b0;
      eR = '0; eG = '0; eB = '0;
   endtask

   // The window index within the frame gives its raster coordinates directly
   function automatic logic expEn();
      int x, y;
      x = mIdx % W;
      y = mIdx / W;
      return (mMode == 1) && winValid && !winSof &&
             (x >= 1) && (x <= W - 2) && (y >= 1) && (y <= H - 2);
   endfunction

   function automatic logic expClr();
      return winValid && winSof && (mMode != 2);
   endfunction

   // Advance the frame model by one clock edge using the inputs just sampled
   task automatic modelStep();
      logic sErr, cap, ovSet;
      if (!reset) begin
         modelReset();
         return;
      end
      sErr = 1'b0;
      cap  = 1'b0;
      case (mMode)
         0: begin
            if (winValid && winSof) begin
               if (winEof) sErr = 1'b1;
               else begin mMode = 1; mIdx = 1; end
            end
         end
         1: begin
            if (winValid) begin
               if (winSof && winEof) begin sErr = 1'b1; mMode = 0; end
               else if (winSof) begin sErr = 1'b1; mIdx = 1; end
               else if (winEof) begin
                  if (mIdx == W * H - 1) begin mMode = 2; mDrain = LAT; end
                  else begin sErr = 1'b1; mMode = 0; end
               end
               else mIdx++;
            end
         end
         default: begin
            if (winValid) sErr = 1'b1;
            if (mDrain == 0) begin cap = 1'b1; mMode = 0; end
            else mDrain--;
         end
      endcase
      ovSet = cap && eValid && !aReady;
      if (cap) begin
         eValid = 1'b1;
         eR = estR; eG = estG; eB = estB;
      end else if (eValid && aReady) begin
         eValid = 1'b0;
      end
      eOverrun = ovSet | (eOverrun & ~errClr);
      eSizeErr = sErr  | (eSizeErr & ~errClr);
   endtask

   // Present one cycle of window inputs, then step the model on the edge
   task automatic applyStimulus(input logic v, input logic s, input logic e);
      winValid = v;
      winSof   = s;
      winEof   = e;
      @(negedge clk);
      @(posedge clk);
      modelStep();
      #1;
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) applyStimulus(1'b0, 1'b0, 1'b0);
   endtask

   task automatic runFrame(input int n, input int eofAt);
      for (int i = 0; i < n; i++) applyStimulus(1'b1, i == 0, i == eofAt);
   endtask

   // Per-cycle comparison of every DUT output against the model
   initial begin
      forever begin
         @(negedge clk);
         checkOutput("est_clr",  estClr,  expClr());
         checkOutput("est_en",   estEn,   expEn());
         checkOutput("a_valid",  aValid,  eValid);
         checkOutput("a_r",      aR,      eR);
         checkOutput("a_g",      aG,      eG);
         checkOutput("a_b",      aB,      eB);
         checkOutput("busy",     busy,    mMode != 0);
         checkOutput("overrun",  overrun, eOverrun);
         checkOutput("size_err", sizeErr, eSizeErr);
         if (estClr) clrCount++;
         if (estEn)  enCount++;
         if (aValid && !prevValid) validCount++;
         prevValid = aValid;
      end
   end

   // Directed scenarios
   initial begin
      int cnt, c0, e0, v0;
      reset = 1'b0;
      winValid = 1'b0; winSof = 1'b0; winEof = 1'b0;
      aReady = 1'b1; errClr = 1'b0;
      estR = 8'h80; estG = 8'h40; estB = 8'h20;
      modelReset();
      idle(2);
      checkOutput("reset_a_valid", aValid, 1'b0);
      checkOutput("reset_busy", busy, 1'b0);
      checkOutput("reset_flags", {overrun, sizeErr}, 2'b00);
      reset = 1'b1;
      idle(1);

      $display("[TB] good frame");
      c0 = clrCount; e0 = enCount;
      runFrame(12, 11);
      cnt = 0;
      while (!aValid && cnt < 20) begin
         applyStimulus(1'b0, 1'b0, 1'b0);
         cnt++;
      end
      checkOutput("capture_latency", cnt, 3);
      checkOutput("good_clr_count", clrCount - c0, 1);
      checkOutput("good_en_count", enCount - e0, 2);
      checkOutput("good_rgb", {aR, aG, aB}, 24'h804020);
      checkOutput("good_size_err", sizeErr, 1'b0);
      idle(2);
      checkOutput("accept_clears_valid", aValid, 1'b0);

      $display("[TB] early eof");
      runFrame(11, 10);
      idle(5);
      checkOutput("early_eof_err", sizeErr, 1'b1);
      checkOutput("early_eof_no_valid", aValid, 1'b0);
      checkOutput("early_eof_idle", busy, 1'b0);
      errClr = 1'b1;
      idle(1);
      errClr = 1'b0;
      checkOutput("err_clr", sizeErr, 1'b0);

      $display("[TB] overrun");
      aReady = 1'b0;
      estR = 8'h11; estG = 8'h22; estB = 8'h33;
      runFrame(12, 11);
      idle(4);
      checkOutput("first_rgb", {aR, aG, aB}, 24'h112233);
      checkOutput("first_no_overrun", overrun, 1'b0);
      estR = 8'h44; estG = 8'h55; estB = 8'h66;
      runFrame(12, 11);
      idle(4);
      checkOutput("overrun_set", overrun, 1'b1);
      checkOutput("overrun_rgb", {aR, aG, aB}, 24'h445566);
      aReady = 1'b1;
      idle(1);
      aReady = 1'b0;
      checkOutput("overrun_accept", aValid, 1'b0);
      errClr = 1'b1;
      idle(1);
      errClr = 1'b0;

      $display("[TB] sof restart");
      aReady = 1'b1;
      estR = 8'h80; estG = 8'h40; estB = 8'h20;
      c0 = clrCount; e0 = enCount; v0 = validCount;
      runFrame(6, -1);
      runFrame(12, 11);
      idle(5);
      checkOutput("restart_err", sizeErr, 1'b1);
      checkOutput("restart_clr_count", clrCount - c0, 2);
      checkOutput("restart_en_count", enCount - e0, 3);
      checkOutput("restart_valid_count", validCount - v0, 1);
      errClr = 1'b1;
      idle(1);
      errClr = 1'b0;

      $display("[TB] reset mid-frame");
      aReady = 1'b0;
      runFrame(12, 11);
      idle(4);
      checkOutput("pre_reset_valid", aValid, 1'b1);
      runFrame(7, -1);
      reset = 1'b0;
      modelReset();
      applyStimulus(1'b1, 1'b0, 1'b0);
      applyStimulus(1'b1, 1'b0, 1'b0);
      checkOutput("in_reset_outputs",
                  {aValid, busy, overrun, sizeErr, estEn, estClr}, 6'b0);
      checkOutput("in_reset_rgb", {aR, aG, aB}, 24'h0);
      reset = 1'b1;
      aReady = 1'b1;
      estR = 8'hA5; estG = 8'h5A; estB = 8'hC3;
      runFrame(12, 11);
      idle(3);
      checkOutput("post_reset_rgb", {aR, aG, aB}, 24'hA55AC3);
      checkOutput("post_reset_err", sizeErr, 1'b0);
      idle(2);

      $display("[TB] windows during drain");
      estR = 8'h12; estG = 8'h34; estB = 8'h56;
      runFrame(12, 11);
      c0 = clrCount; e0 = enCount; v0 = validCount;
      applyStimulus(1'b1, 1'b1, 1'b0);
      applyStimulus(1'b1, 1'b0, 1'b0);
      errClr = 1'b1;
      applyStimulus(1'b1, 1'b0, 1'b0);
      errClr = 1'b0;
      checkOutput("drain_rgb", {aR, aG, aB}, 24'h123456);
      for (int i = 3; i < 12; i++) applyStimulus(1'b1, 1'b0, i == 11);
      idle(5);
      checkOutput("drain_clr_count", clrCount - c0, 0);
      checkOutput("drain_en_count", enCount - e0, 0);
      checkOutput("drain_valid_count", validCount - v0, 1);
      checkOutput("drain_err_set_wins", sizeErr, 1'b1);
      errClr = 1'b1;
      idle(1);
      errClr = 1'b0;

      $display("[TB] sof with eof");
      applyStimulus(1'b1, 1'b1, 1'b1);
      idle(1);
      checkOutput("sof_eof_err", sizeErr, 1'b1);
      checkOutput("sof_eof_idle", busy, 1'b0);
      idle(2);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatch);
      $finish;
   end

endmodule

// File: doc/airlight_frame_ctrl.md
# airlight_frame_ctrl

Frame-level sequencer for the atmospheric-light estimator. It sits between the 3x3 RGB window generator and the global estimator that tracks the running dark-channel minimum and its RGB values. It clears the estimator at start of frame, gates it to interior windows only, checks frame geometry, waits out the estimator pipeline, and presents the per-frame atmospheric light (R,G,B) downstream through a valid/ready register.

## Interface
- IMG_W, 640, frame width in pixels (>=3)
- IMG_H, 480, frame height in pixels (>=3)
- EST_LAT, 2, estimator latency in cycles from last est_en to stable est_r/g/b (>=1)
- DW, 8, channel width
- clk  in  1  single clock, all logic on rising edge
- reset  in  1  asynchronous, active-low; forces every register to its reset value
- win_valid  in  1  window-generator output valid, one window per pixel, raster order
- win_sof  in  1  qualifies the first window of a frame (pixel 0,0); meaningful only with win_valid
- win_eof  in  1  qualifies the last window of a frame; meaningful only with win_valid
- est_clr  out  1  estimator clear, combinational: win_valid & win_sof & state!=DRAIN
- est_en  out  1  estimator window enable, combinational
- est_r, est_g, est_b  in  DW  estimator result channels
- a_r, a_g, a_b  out  DW  captured atmospheric light, reset 0
- a_valid  out  1  result valid, reset 0
- a_ready  in  1  downstream accept
- busy  out  1  state!=IDLE, reset 0
- overrun  out  1  sticky: unaccepted result overwritten, reset 0
- size_err  out  1  sticky: frame geometry/protocol violation, reset 0
- err_clr  in  1  synchronous clear of overrun and size_err (set wins if coincident)

## Operation
- States IDLE, RUN, DRAIN; reset -> IDLE.
- Counters col (0..IMG_W-1), row (0..IMG_H-1), width $clog2 of each bound; advance on every win_valid in RUN; col wraps to 0 and increments row; row saturates at IMG_H-1 with an internal overflow flag.
- IDLE: win_valid&win_sof -> RUN, col=1,row=0 (sof window is pixel 0). Other windows ignored, est_en=0.
- RUN: est_en = win_valid & (1<=row<=IMG_H-2) & (1<=col<=IMG_W-2) using the current window's coordinates. Border windows never reach the estimator.
- RUN, win_eof: if col==IMG_W-1, row==IMG_H-1, no overflow -> DRAIN with drain counter=EST_LAT; else size_err=1 -> IDLE, no result.
- RUN, win_sof (missing eof): size_err=1, restart frame in RUN (est_clr asserts, counters reset to col=1,row=0).
- win_sof&win_eof in same window: size_err=1 -> IDLE.
- DRAIN: est_en=0, est_clr=0; counter decrements; at 0, capture est_r/g/b into a_r/a_g/a_b, a_valid=1 -> IDLE. Any win_valid in DRAIN sets size_err and is dropped. A sof arriving in DRAIN is not replayed, so that frame is skipped.
- Output register: a_valid&a_ready clears a_valid unless a capture occurs that cycle. A capture while a_valid&!a_ready sets overrun and overwrites. A capture with a_valid&a_ready keeps a_valid=1 without overrun.
- Reset mid-frame: state IDLE, counters 0, outputs to reset values. The estimator is not cleared until the next accepted sof.

## Timing
- est_clr/est_en: zero latency, same cycle as the window (combinational from win_* and registered state/counters).
- Capture occurs EST_LAT+1 cycles after the eof window edge. a_valid rises on that edge.
- The earliest legal next sof is in the cycle after capture (state IDLE). Minimum inter-frame gap is EST_LAT+1 cycles.
- Sticky flags set on the clock edge after the offending window.

## Test plan
- IMG_W=4, IMG_H=3, EST_LAT=2, 12 back-to-back windows with sof/eof, est inputs held R=0x80,G=0x40,B=0x20 -> est_clr on cycle 0 only; est_en exactly on pixels (1,1),(1,2); a_valid rises 3 cycles after eof with a=80/40/20; size_err=0.
- Same frame with eof on window 11 -> size_err=1, no a_valid, state IDLE; err_clr -> size_err=0.
- Two frames, a_ready held 0 -> second capture sets overrun=1, a_* show second frame's values; a_ready=1 for one cycle -> a_valid=0.
- sof re-asserted at window 6 of a frame, then a full 12-window frame -> size_err=1, est_clr pulses twice, single valid result.
- reset low during window 7, release, full frame -> all outputs 0 during reset; the following frame completes normally.
- Windows (including sof) during DRAIN -> est_en/est_clr stay 0, size_err=1, captured result is from the first frame.
